// File: rtl/tdc_meas_arbiter.sv
// tdc_meas_arbiter: collects NUM_CH TDC measurements into a shared FIFO,
// tags each entry with its channel byte and paces them out to uart_tx.
//
// Ports:
//   clk_100m    in   system clock, 100 MHz
//   rst_n       in   synchronous, active-low reset
//   meas_in     in   channel c measurement at [c*MEAS_W +: MEAS_W]
//   meas_valid  in   per-channel one-cycle strobe
//   tx_data     out  {channel byte, measurement} to uart_tx
//   tx_start    out  one-cycle start pulse to uart_tx
//   tx_busy     in   uart_tx busy
//   fifo_level  out  FIFO occupancy, 0..FIFO_DEPTH
//   overflow    out  sticky per-channel lost-measurement flags
//   ovf_clr     in   clears overflow and drop_count
//   drop_count  out  saturating lost-measurement count
//
// Optional feature macro: TDC_ARB_DROP_CNT_EN builds the drop counter;
// without it drop_count is tied to zero.

module tdc_meas_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int MEAS_W      = 40,
    parameter int FIFO_DEPTH  = 8,
    parameter int TX_INTERVAL = 5_000_000,
    localparam int CH_W       = 8,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk_100m,
    input  logic                     rst_n,
    input  logic [NUM_CH*MEAS_W-1:0] meas_in,
    input  logic [NUM_CH-1:0]        meas_valid,
    output logic [CH_W+MEAS_W-1:0]   tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic [LVL_W-1:0]         fifo_level,
    output logic [NUM_CH-1:0]        overflow,
    input  logic                     ovf_clr,
    output logic [15:0]              drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(TX_INTERVAL + 1);
    localparam int ENT_W = CH_W + MEAS_W;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GUARD
    } state_e;

    // ---------------- capture ----------------
    logic [MEAS_W-1:0] pend_q [NUM_CH];
    logic [MEAS_W-1:0] pend_d [NUM_CH];
    logic [NUM_CH-1:0] pend_vld_q;
    logic [NUM_CH-1:0] pend_vld_d;
    logic [NUM_CH-1:0] drain;
    logic [NUM_CH-1:0] drop;

    // ---------------- arbiter ----------------
    logic [IDX_W-1:0]  rr_q;
    logic [IDX_W-1:0]  rr_d;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic              push;

    // ---------------- fifo ----------------
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]  wdata;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic              full;
    logic              empty;
    logic              pop;

    // ---------------- output ----------------
    state_e            state_q;
    state_e            state_d;
    logic [ENT_W-1:0]  tx_data_q;
    logic [ENT_W-1:0]  tx_data_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] ovf_d;

    // Round-robin search starting at rr_q. Scanning offsets from high
    // to low lets the nearest pending channel be the final winner.
    always_comb begin
        int k;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        k       = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            k = int'(rr_q) + i;
            if (k >= NUM_CH) begin
                k = k - NUM_CH;
            end
            if (pend_vld_q[k[IDX_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = k[IDX_W-1:0];
            end
        end
    end

    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign push  = gnt_vld && !full;
    assign wdata = {CH_W'(gnt_idx), pend_q[gnt_idx]};

    always_comb begin
        rr_d = rr_q;
        if (push) begin
            if (gnt_idx == IDX_W'(NUM_CH - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = gnt_idx + IDX_W'(1);
            end
        end
    end

    // A channel being pushed this cycle frees its slot, so a new strobe
    // on it simply reloads; otherwise a strobe onto a full slot is a drop.
    always_comb begin
        drain = '0;
        if (push) begin
            drain[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        drop       = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (meas_valid[c]) begin
                pend_d[c]     = meas_in[c*MEAS_W +: MEAS_W];
                pend_vld_d[c] = 1'b1;
                if (pend_vld_q[c] && !drain[c]) begin
                    drop[c] = 1'b1;
                end
            end else if (drain[c]) begin
                pend_vld_d[c] = 1'b0;
            end
        end
    end

    always_comb begin
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // A drop in the same cycle as ovf_clr survives the clear.
    assign ovf_d = (ovf_clr ? '0 : ovf_q) | drop;

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        tx_data_d = tx_data_q;
        unique case (state_q)
            IDLE: begin
                if (!empty && !tx_busy &&
                    cnt_q == CNT_W'(TX_INTERVAL)) begin
                    state_d   = SEND;
                    pop       = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                end
            end
            SEND: begin
                state_d = GUARD;
            end
            // uart_tx raises busy a cycle late; skip one look at it.
            GUARD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx_start = (state_q == SEND);

    always_comb begin
        if (tx_start) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(TX_INTERVAL)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_100m) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pend_q[c] <= '0;
            end
            pend_vld_q <= '0;
            rr_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            state_q    <= IDLE;
            tx_data_q  <= '0;
            cnt_q      <= CNT_W'(TX_INTERVAL);
            ovf_q      <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            rr_q       <= rr_d;
            level_q    <= level_d;
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: only entries below level_q are ever read.
    always_ff @(posedge clk_100m) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

`ifdef TDC_ARB_DROP_CNT_EN
    logic [15:0] dcnt_q;
    logic [15:0] dcnt_d;
    logic [4:0]  n_drop;
    logic [16:0] dsum;

    always_comb begin
        n_drop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            n_drop = n_drop + 5'(drop[c]);
        end
        dsum = {1'b0, (ovf_clr ? 16'd0 : dcnt_q)} + 17'(n_drop);
        dcnt_d = dsum[16] ? 16'hFFFF : dsum[15:0];
    end

    always_ff @(posedge clk_100m) begin
        if (!rst_n) begin
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
        end
    end

    assign drop_count = dcnt_q;
`else
    assign drop_count = 16'd0;
`endif

    assign tx_data    = tx_data_q;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_tdc_meas_arbiter.sv
// tb_tdc_meas_arbiter: directed checks of tdc_meas_arbiter with
// NUM_CH=4, MEAS_W=40, FIFO_DEPTH=4, TX_INTERVAL=10.

module tb_tdc_meas_arbiter;

    localparam int NUM_CH      = 4;
    localparam int MEAS_W      = 40;
    localparam int FIFO_DEPTH  = 4;
    localparam int TX_INTERVAL = 10;

`ifdef TDC_ARB_DROP_CNT_EN
    localparam logic [15:0] DROP1 = 16'd1;
`else
    localparam logic [15:0] DROP1 = 16'd0;
`endif

    logic                     clk_100m = 1'b0;
    logic                     rst_n;
    logic [NUM_CH*MEAS_W-1:0] meas_in;
    logic [NUM_CH-1:0]        meas_valid;
    logic [47:0]              tx_data;
    logic                     tx_start;
    logic                     tx_busy;
    logic [2:0]               fifo_level;
    logic [NUM_CH-1:0]        overflow;
    logic                     ovf_clr;
    logic [15:0]              drop_count;

    int checks = 0;
    int fails  = 0;
    logic [47:0] expq [$];

    always #5 clk_100m = ~clk_100m;

    tdc_meas_arbiter #(
        .NUM_CH      (NUM_CH),
        .MEAS_W      (MEAS_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TX_INTERVAL (TX_INTERVAL)
    ) dut (
        .clk_100m   (clk_100m),
        .rst_n      (rst_n),
        .meas_in    (meas_in),
        .meas_valid (meas_valid),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .drop_count (drop_count)
    );

    task automatic tick();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int ch, input logic [39:0] v);
        meas_in[ch*MEAS_W +: MEAS_W] = v;
        meas_valid[ch] = 1'b1;
        tick();
        meas_valid = '0;
    endtask

    // Wait for every queued frame, checking data order and spacing.
    task automatic drain(input string tag, input int budget);
        int cyc;
        int last;
        cyc  = 0;
        last = -100;
        while (expq.size() > 0 && cyc < budget) begin
            tick();
            cyc++;
            if (tx_start === 1'b1) begin
                check({tag, "_data"}, 64'(tx_data), 64'(expq.pop_front()));
                check({tag, "_gap"}, 64'(cyc - last >= TX_INTERVAL),
                      64'(1'b1));
                last = cyc;
            end
        end
        check({tag, "_left"}, 64'(expq.size()), 64'(0));
    endtask

    initial begin
        rst_n      = 1'b0;
        meas_in    = '0;
        meas_valid = '0;
        tx_busy    = 1'b0;
        ovf_clr    = 1'b0;
        tick();
        tick();
        check("rst_tx_data", 64'(tx_data), 64'(0));
        check("rst_tx_start", 64'(tx_start), 64'(0));
        check("rst_level", 64'(fifo_level), 64'(0));
        check("rst_ovf", 64'(overflow), 64'(0));
        check("rst_drop", 64'(drop_count), 64'(0));
        rst_n = 1'b1;
        tick();

        // single ch2 measurement, minimum latency
        pulse(2, 40'h12_3456_789A);
        check("t1_start_t1", 64'(tx_start), 64'(0));
        tick();
        check("t1_level_t2", 64'(fifo_level), 64'(1));
        check("t1_start_t2", 64'(tx_start), 64'(0));
        tick();
        check("t1_start_t3", 64'(tx_start), 64'(1));
        check("t1_data", 64'(tx_data), 64'(48'h02_12_3456_789A));
        check("t1_level_t3", 64'(fifo_level), 64'(0));
        tick();
        check("t1_start_t4", 64'(tx_start), 64'(0));

        // all four channels at once, fresh arbiter
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        meas_in = {40'd4, 40'd3, 40'd2, 40'd1};
        meas_valid = 4'hF;
        tick();
        meas_valid = '0;
        expq.push_back({8'h00, 40'd1});
        expq.push_back({8'h01, 40'd2});
        expq.push_back({8'h02, 40'd3});
        expq.push_back({8'h03, 40'd4});
        drain("t3", 80);
        check("t3_ovf", 64'(overflow), 64'(0));

        // fill while busy, then one overwrite on ch1
        tx_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            meas_in[1*MEAS_W +: MEAS_W] = 40'(100 + i);
            meas_valid = 4'b0010;
            tick();
        end
        meas_valid = '0;
        check("t4_level", 64'(fifo_level), 64'(4));
        check("t4_ovf", 64'(overflow), 64'(4'b0010));
        check("t4_drop", 64'(drop_count), 64'(DROP1));
        for (int i = 0; i < 4; i++) begin
            expq.push_back({8'h01, 40'(100 + i)});
        end
        expq.push_back({8'h01, 40'd105});
        tx_busy = 1'b0;
        drain("t4", 120);

        // push and pop in the same cycle at level 2
        tx_busy = 1'b1;
        pulse(0, 40'hA0);
        tick();
        pulse(0, 40'hB0);
        tick();
        repeat (12) tick();
        check("t5_level_a", 64'(fifo_level), 64'(2));
        meas_in[0 +: MEAS_W] = 40'hC0;
        meas_valid = 4'b0001;
        tick();
        meas_valid = '0;
        tx_busy = 1'b0;
        check("t5_level_b", 64'(fifo_level), 64'(2));
        tick();
        check("t5_start", 64'(tx_start), 64'(1));
        check("t5_level_c", 64'(fifo_level), 64'(2));
        check("t5_data_a", 64'(tx_data), 64'({8'h00, 40'hA0}));
        expq.push_back({8'h00, 40'hB0});
        expq.push_back({8'h00, 40'hC0});
        drain("t5", 60);

        // reset with entries queued
        tx_busy = 1'b1;
        pulse(3, 40'd1);
        pulse(3, 40'd2);
        pulse(3, 40'd3);
        tick();
        tick();
        check("t6_level_pre", 64'(fifo_level), 64'(3));
        check("t6_ovf_pre", 64'(overflow), 64'(4'b0010));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_level", 64'(fifo_level), 64'(0));
        check("t6_start", 64'(tx_start), 64'(0));
        check("t6_ovf", 64'(overflow), 64'(0));
        check("t6_drop", 64'(drop_count), 64'(0));
        tx_busy = 1'b0;
        pulse(2, 40'h55);
        check("t6_start_t1", 64'(tx_start), 64'(0));
        tick();
        tick();
        check("t6_start_t3", 64'(tx_start), 64'(1));
        check("t6_data", 64'(tx_data), 64'({8'h02, 40'h55}));

        // ovf_clr concurrent with a new ch3 drop
        tx_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            meas_in[0 +: MEAS_W] = 40'(i);
            meas_valid = 4'b0001;
            tick();
        end
        meas_valid = '0;
        check("t7_ovf_ch0", 64'(overflow), 64'(4'b0001));
        pulse(3, 40'h33);
        tick();
        meas_in[3*MEAS_W +: MEAS_W] = 40'h34;
        meas_valid = 4'b1000;
        ovf_clr = 1'b1;
        tick();
        meas_valid = '0;
        ovf_clr = 1'b0;
        check("t7_ovf_ch3", 64'(overflow), 64'(4'b1000));
        check("t7_drop", 64'(drop_count), 64'(DROP1));
        check("t7_level", 64'(fifo_level), 64'(4));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t7_ovf_clr", 64'(overflow), 64'(0));
        check("t7_drop_clr", 64'(drop_count), 64'(0));

        // last grant was ch0, so ch3 is pushed before ch0
        for (int i = 0; i < 4; i++) begin
            expq.push_back({8'h00, 40'(i)});
        end
        expq.push_back({8'h03, 40'h34});
        expq.push_back({8'h00, 40'd5});
        tx_busy = 1'b0;
        drain("t7", 120);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
